// File: rtl/fp_arith_seq_if.sv
// Start/busy/done handshake plus operand and result bundle for fp_arith_seq.
interface fp_arith_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (output start, op, a, b, input busy, done, result, flags);
    modport slave  (input start, op, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp_arith_seq.sv
// Sequenced IEEE-754 add/sub/mul with RNE rounding and flush-to-zero denormals.
module fp_arith_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRS_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_arith_seq_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + GRS_W + 2;
    localparam int H     = MAN_W + GRS_W;
    localparam int N     = MAN_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int FOLD  = MAN_W - GRS_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, EXEC, NORM, ROUND, FINISH} state_t;
    state_t state_reg, state_next;

    logic [1:0]           op_reg;
    logic [W-1:0]         a_reg, b_reg;
    logic [EXP_W-1:0]     exp_a_reg, exp_b_reg;
    logic [SIG_W-1:0]     sig_a_reg, sig_b_reg, sig_reg;
    logic signed [EW-1:0] exp_reg;
    logic                 sign_reg, eff_sub_reg, zero_reg;
    logic                 special_reg, spec_inv_reg;
    logic [W-1:0]         spec_res_reg;
    logic [2*N:0]         prod_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [W-1:0]         result_reg;
    logic [3:0]           flags_reg;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic sa, sb, sb_eff, is_mul;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sa     = a_reg[W-1];
    assign sb     = b_reg[W-1];
    assign ea     = a_reg[W-2 -: EXP_W];
    assign eb     = b_reg[W-2 -: EXP_W];
    assign fa     = a_reg[MAN_W-1:0];
    assign fb     = b_reg[MAN_W-1:0];
    assign sb_eff = sb ^ op_reg[0];
    assign is_mul = (op_reg == 2'b10);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    // Operands that never reach the datapath: NaN/inf/zero/reserved op.
    logic special, spec_inv;
    logic [W-1:0] spec_res;
    always_comb begin
        special  = 1'b1;
        spec_inv = 1'b0;
        spec_res = '0;
        if (op_reg == 2'b11 || a_nan || b_nan) begin
            spec_inv = 1'b1;
            spec_res = QNAN;
        end else if (is_mul) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                spec_inv = 1'b1;
                spec_res = QNAN;
            end else if (a_inf || b_inf)   spec_res = {sa ^ sb, INF};
            else if (a_zero || b_zero)     spec_res = {sa ^ sb, {(W-1){1'b0}}};
            else                           special  = 1'b0;
        end else begin
            if (a_inf && b_inf && (sa != sb_eff)) begin
                spec_inv = 1'b1;
                spec_res = QNAN;
            end else if (a_inf)            spec_res = {sa, INF};
            else if (b_inf)                spec_res = {sb_eff, INF};
            else if (a_zero && b_zero)     spec_res = {sa & sb_eff, {(W-1){1'b0}}};
            else if (b_zero)               spec_res = a_reg;
            else if (a_zero)               spec_res = {sb_eff, b_reg[W-2:0]};
            else                           special  = 1'b0;
        end
    end

    logic                swap;
    logic [EXP_W-1:0]    e_big, e_diff;
    logic [SIG_W-1:0]    m_big, m_small, m_shift, lost_mask;
    always_comb begin
        swap      = {exp_b_reg, sig_b_reg} > {exp_a_reg, sig_a_reg};
        e_big     = swap ? exp_b_reg : exp_a_reg;
        e_diff    = swap ? (exp_b_reg - exp_a_reg) : (exp_a_reg - exp_b_reg);
        m_big     = swap ? sig_b_reg : sig_a_reg;
        m_small   = swap ? sig_a_reg : sig_b_reg;
        lost_mask = ~({SIG_W{1'b1}} << e_diff);
        m_shift   = (m_small >> e_diff) | {{(SIG_W-1){1'b0}}, |(m_small & lost_mask)};
    end

    // Shift-add multiplier: multiplier sits in the low half and is consumed LSB first.
    logic [N:0]       mul_upper;
    logic [2*N:0]     prod_step;
    logic [SIG_W-1:0] prod_fold;
    always_comb begin
        mul_upper = prod_reg[2*N:N] + (prod_reg[0] ? {1'b0, sig_a_reg[H:GRS_W]} : '0);
        prod_step = {mul_upper, prod_reg[N-1:0]} >> 1;
        prod_fold = {prod_step[2*N-1:FOLD+1], prod_step[FOLD] | (|prod_step[FOLD-1:0])};
    end

    logic                 g_bit, r_bit, s_bit, round_up;
    logic [N:0]           mant_up;
    logic [MAN_W-1:0]     frac_out;
    logic signed [EW-1:0] exp_out;
    logic [W-1:0]         round_res;
    logic [3:0]           round_flags;
    always_comb begin
        g_bit    = sig_reg[GRS_W-1];
        r_bit    = sig_reg[GRS_W-2];
        s_bit    = |sig_reg[GRS_W-3:0];
        round_up = g_bit && (r_bit || s_bit || sig_reg[GRS_W]);
        mant_up  = {1'b0, sig_reg[H:GRS_W]} + {{N{1'b0}}, round_up};
        frac_out = mant_up[N] ? mant_up[N-1:1] : mant_up[MAN_W-1:0];
        exp_out  = exp_reg + (mant_up[N] ? ONE : '0);
        if (special_reg) begin
            round_res   = spec_res_reg;
            round_flags = {spec_inv_reg, 3'b000};
        end else if (zero_reg) begin
            round_res   = '0;
            round_flags = 4'b0000;
        end else if (!exp_out[EW-1] && exp_out >= EMAX) begin
            round_res   = {sign_reg, INF};
            round_flags = 4'b0101;
        end else if (exp_out[EW-1] || exp_out == '0) begin
            round_res   = {sign_reg, {(W-1){1'b0}}};
            round_flags = 4'b0011;
        end else begin
            round_res   = {sign_reg, exp_out[EXP_W-1:0], frac_out};
            round_flags = {3'b000, g_bit | r_bit | s_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = UNPACK;
            UNPACK:  state_next = special ? ROUND : (is_mul ? EXEC : ALIGN);
            ALIGN:   state_next = EXEC;
            EXEC:    if (!is_mul || cnt_reg == CNT_W'(N - 1)) state_next = NORM;
            NORM:    if (sig_reg == '0 || sig_reg[SIG_W-1] || sig_reg[H] || sig_reg[H-1])
                         state_next = ROUND;
            ROUND:   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    a_reg  <= bus.a;
                    b_reg  <= bus.b;
                    op_reg <= bus.op;
                end
                UNPACK: begin
                    special_reg  <= special;
                    spec_inv_reg <= spec_inv;
                    spec_res_reg <= spec_res;
                    zero_reg     <= 1'b0;
                    exp_a_reg    <= ea;
                    exp_b_reg    <= eb;
                    sig_a_reg    <= {2'b01, fa, {GRS_W{1'b0}}};
                    sig_b_reg    <= {2'b01, fb, {GRS_W{1'b0}}};
                    eff_sub_reg  <= sa ^ sb_eff;
                    sign_reg     <= sa ^ sb;
                    exp_reg      <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    prod_reg     <= {{(N+1){1'b0}}, 1'b1, fb};
                    cnt_reg      <= '0;
                end
                ALIGN: begin
                    sign_reg  <= swap ? sb_eff : sa;
                    exp_reg   <= $signed({2'b00, e_big});
                    sig_a_reg <= m_big;
                    sig_b_reg <= m_shift;
                end
                EXEC: begin
                    if (is_mul) begin
                        prod_reg <= prod_step;
                        cnt_reg  <= cnt_reg + 1'b1;
                        sig_reg  <= prod_fold;
                    end else begin
                        sig_reg <= eff_sub_reg ? (sig_a_reg - sig_b_reg) : (sig_a_reg + sig_b_reg);
                    end
                end
                NORM: begin
                    if (sig_reg == '0) begin
                        zero_reg <= 1'b1;
                    end else if (sig_reg[SIG_W-1]) begin
                        sig_reg <= {1'b0, sig_reg[SIG_W-1:2], sig_reg[1] | sig_reg[0]};
                        exp_reg <= exp_reg + ONE;
                    end else if (!sig_reg[H]) begin
                        sig_reg <= sig_reg << 1;
                        exp_reg <= exp_reg - ONE;
                    end
                end
                ROUND: begin
                    result_reg <= round_res;
                    flags_reg  <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = (state_reg == FINISH);
    assign bus.result = result_reg;
    assign bus.flags  = flags_reg;
endmodule

// File: tb/tb_fp_arith_seq.sv
// Directed-vector bench for fp_arith_seq in single precision.
`timescale 1ns/1ps
module tb_fp_arith_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] r_res;
    logic [3:0]  r_flg;
    int          r_lat;

    fp_arith_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_arith_seq #(.EXP_W(8), .MAN_W(23), .GRS_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        r_lat = 1;
        while (bus.done !== 1'b1 && r_lat < 100) begin
            @(negedge clk);
            r_lat++;
        end
        r_res = bus.result;
        r_flg = bus.flags;
        $display("op=%0d a=%h b=%h -> result=%h flags=%b latency=%0d", op, a, b, r_res, r_flg, r_lat);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", bus.result); end
        checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b expected 0000", bus.flags); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        logic [3:0]  vf [4];
        va = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vb = '{32'h40000000, 32'h33800000, 32'h33C00000, 32'hBF800000};
        vr = '{32'h40400000, 32'h3F800000, 32'h3F800001, 32'h3F800000};
        vf = '{4'b0000,      4'b0001,      4'b0001,      4'b0000};
        for (int i = 0; i < 4; i++) begin
            run_op(2'b00, va[i], vb[i]);
            checks++; if (r_res !== vr[i]) begin errors++; $display("FAIL add[%0d] result got %h expected %h", i, r_res, vr[i]); end
            checks++; if (r_flg !== vf[i]) begin errors++; $display("FAIL add[%0d] flags got %b expected %b", i, r_flg, vf[i]); end
            if (i == 0) begin
                checks++; if (r_lat !== 6) begin errors++; $display("FAIL add_latency got %0d expected 6", r_lat); end
            end
        end
    endtask

    task automatic test_sub();
        logic [1:0]  vo [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        vo = '{2'b01,        2'b01,        2'b01,        2'b00};
        va = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h80000000};
        vb = '{32'h3F800000, 32'h33800000, 32'h40400000, 32'h80000000};
        vr = '{32'h00000000, 32'h3F7FFFFF, 32'hC0400000, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            run_op(vo[i], va[i], vb[i]);
            checks++; if (r_res !== vr[i]) begin errors++; $display("FAIL sub[%0d] result got %h expected %h", i, r_res, vr[i]); end
            checks++; if (r_flg !== 4'b0000) begin errors++; $display("FAIL sub[%0d] flags got %b expected 0000", i, r_flg); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vr [5];
        logic [3:0]  vf [5];
        va = '{32'h3FC00000, 32'hC0000000, 32'h7F7FFFFF, 32'h00800000, 32'h00400000};
        vb = '{32'h40200000, 32'h40400000, 32'h40000000, 32'h00800000, 32'h3F800000};
        vr = '{32'h40700000, 32'hC0C00000, 32'h7F800000, 32'h00000000, 32'h00000000};
        vf = '{4'b0000,      4'b0000,      4'b0101,      4'b0011,      4'b0000};
        for (int i = 0; i < 5; i++) begin
            run_op(2'b10, va[i], vb[i]);
            checks++; if (r_res !== vr[i]) begin errors++; $display("FAIL mul[%0d] result got %h expected %h", i, r_res, vr[i]); end
            checks++; if (r_flg !== vf[i]) begin errors++; $display("FAIL mul[%0d] flags got %b expected %b", i, r_flg, vf[i]); end
            if (i == 0) begin
                checks++; if (r_lat !== 28) begin errors++; $display("FAIL mul_latency got %0d expected 28", r_lat); end
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  vo [5];
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vr [5];
        logic [3:0]  vf [5];
        vo = '{2'b01,        2'b11,        2'b10,        2'b00,        2'b00};
        va = '{32'h7F800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001};
        vb = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000};
        vr = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000};
        vf = '{4'b1000,      4'b1000,      4'b1000,      4'b0000,      4'b1000};
        for (int i = 0; i < 5; i++) begin
            run_op(vo[i], va[i], vb[i]);
            checks++; if (r_res !== vr[i]) begin errors++; $display("FAIL special[%0d] result got %h expected %h", i, r_res, vr[i]); end
            checks++; if (r_flg !== vf[i]) begin errors++; $display("FAIL special[%0d] flags got %b expected %b", i, r_flg, vf[i]); end
            if (i == 0) begin
                checks++; if (r_lat !== 3) begin errors++; $display("FAIL special_latency got %0d expected 3", r_lat); end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        bus.op = 2'b10; bus.a = 32'h3FC00000; bus.b = 32'h40200000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset asserted during mul: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b expected 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h expected 00000000", bus.result); end
        checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL midreset_flags got %b expected 0000", bus.flags); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stale_done got %b expected 0", seen); end
        run_op(2'b00, 32'h3F800000, 32'h3F800000);
        checks++; if (r_res !== 32'h40000000) begin errors++; $display("FAIL midreset_relaunch result got %h expected 40000000", r_res); end
        checks++; if (r_lat !== 6) begin errors++; $display("FAIL midreset_relaunch latency got %0d expected 6", r_lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.op = 2'b00; bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 32'h40A00000; bus.b = 32'h40A00000;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("b2b first: result=%h flags=%b latency=%0d", bus.result, bus.flags, lat);
        checks++; if (bus.result !== 32'h40400000) begin errors++; $display("FAIL b2b_first result got %h expected 40400000", bus.result); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_first latency got %0d expected 6", lat); end
        bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.start = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done_cycle busy got %b expected 0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("b2b relaunch: result=%h flags=%b latency=%0d", bus.result, bus.flags, lat);
        checks++; if (bus.result !== 32'h40000000) begin errors++; $display("FAIL b2b_relaunch result got %h expected 40000000", bus.result); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_relaunch latency got %0d expected 6", lat); end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_special();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
